// File: rtl/mem_bus_pkg.sv
// Shared definitions for the core memory bus: size codes, initiator FSM states, strobe width.
// Used by the initiator, the SRAM responder and the LSU.
package mem_bus_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int STRB_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    RESP
  } state_t;

  // Size 3 has no legal alignment, so it always reports misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/axi_lite_mem_master_if.sv
// AXI-lite-style read/write channels between the memory initiator and the SRAM responder.
interface axi_lite_mem_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = 8
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid, arready;
  logic [DATA_W-1:0] rdata;
  logic              rresp, rvalid, rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid, awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid, wready;
  logic              bresp, bvalid, bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/mem_align.sv
// Byte-lane alignment: store-side data shift and strobes, load-side shift and sign/zero extension.
module mem_align #(
  parameter int DATA_W = 32,
  parameter int STRB_W = 8
) (
  input  logic [1:0]        st_size,
  input  logic [1:0]        st_off,
  input  logic [DATA_W-1:0] st_wdata,
  output logic [DATA_W-1:0] st_wdata_sh,
  output logic [STRB_W-1:0] st_wstrb,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_rdata_ext
);
  import mem_bus_pkg::*;

  logic [3:0]        strb4;
  logic [DATA_W-1:0] ld_sh;

  assign st_wdata_sh = st_wdata << {st_off, 3'b000};
  assign ld_sh       = ld_rdata >> {ld_off, 3'b000};
  // Only the low four strobe lanes exist on a 32-bit bus.
  assign st_wstrb    = {{(STRB_W-4){1'b0}}, strb4};

  always_comb begin
    strb4 = 4'hF;
    case (st_size)
      SZ_B:    strb4 = 4'b0001 << st_off;
      SZ_H:    strb4 = 4'b0011 << st_off;
      default: strb4 = 4'hF;
    endcase
  end

  always_comb begin
    ld_rdata_ext = ld_rdata;
    case (ld_size)
      SZ_B:    ld_rdata_ext = {{(DATA_W-8){~ld_unsigned & ld_sh[7]}}, ld_sh[7:0]};
      SZ_H:    ld_rdata_ext = {{(DATA_W-16){~ld_unsigned & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_rdata_ext = ld_rdata;
    endcase
  end

endmodule

// File: rtl/axi_lite_mem_master.sv
// Single-outstanding memory initiator: turns LSU/IFU load/store requests into AR/R or AW+W/B handshakes.
module axi_lite_mem_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = mem_bus_pkg::STRB_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  axi_lite_mem_master_if.master bus
);
  import mem_bus_pkg::*;

  state_t            state;
  logic [1:0]        size_q, off_q;
  logic              uns_q, b_got;
  logic [DATA_W-1:0] st_wdata, ld_rdata;
  logic [STRB_W-1:0] st_wstrb;
  logic              aw_done, w_done, b_hit;
  logic              unused_resp;

  mem_align #(.DATA_W(DATA_W), .STRB_W(STRB_W)) u_align (
    .st_size      (req_size),
    .st_off       (req_addr[1:0]),
    .st_wdata     (req_wdata),
    .st_wdata_sh  (st_wdata),
    .st_wstrb     (st_wstrb),
    .ld_size      (size_q),
    .ld_unsigned  (uns_q),
    .ld_off       (off_q),
    .ld_rdata     (bus.rdata),
    .ld_rdata_ext (ld_rdata)
  );

  assign req_ready   = (state == IDLE);
  assign aw_done     = !bus.awvalid || bus.awready;
  assign w_done      = !bus.wvalid  || bus.wready;
  assign b_hit       = bus.bvalid && bus.bready;
  // Bus response codes carry no meaning for this core.
  assign unused_resp = bus.rresp ^ bus.bresp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      size_q      <= '0;
      off_q       <= '0;
      uns_q       <= 1'b0;
      b_got       <= 1'b0;
      bus.araddr  <= '0;
      bus.arvalid <= 1'b0;
      bus.rready  <= 1'b0;
      bus.awaddr  <= '0;
      bus.awvalid <= 1'b0;
      bus.wdata   <= '0;
      bus.wstrb   <= '0;
      bus.wvalid  <= 1'b0;
      bus.bready  <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          size_q <= req_size;
          uns_q  <= req_unsigned;
          off_q  <= req_addr[1:0];
          if (misaligned(req_size, req_addr[1:0])) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            state      <= RESP;
          end else if (req_we) begin
            bus.awaddr  <= {req_addr[ADDR_W-1:2], 2'b00};
            bus.wdata   <= st_wdata;
            bus.wstrb   <= st_wstrb;
            bus.awvalid <= 1'b1;
            bus.wvalid  <= 1'b1;
            bus.bready  <= 1'b1;
            b_got       <= 1'b0;
            state       <= WR_REQ;
          end else begin
            bus.araddr  <= {req_addr[ADDR_W-1:2], 2'b00};
            bus.arvalid <= 1'b1;
            bus.rready  <= 1'b1;
            state       <= RD_ADDR;
          end
        end
        RD_ADDR: if (bus.arready) begin
          bus.arvalid <= 1'b0;
          // A responder may return data in the same cycle it takes the address.
          if (bus.rvalid) begin
            bus.rready <= 1'b0;
            resp_rdata <= ld_rdata;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            state      <= RESP;
          end else begin
            state <= RD_DATA;
          end
        end
        RD_DATA: if (bus.rvalid) begin
          bus.rready <= 1'b0;
          resp_rdata <= ld_rdata;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        WR_REQ: begin
          if (bus.awvalid && bus.awready) bus.awvalid <= 1'b0;
          if (bus.wvalid && bus.wready)   bus.wvalid  <= 1'b0;
          // An early write response is remembered so it is not lost before WR_RESP.
          if (b_hit) begin
            b_got      <= 1'b1;
            bus.bready <= 1'b0;
          end
          if (aw_done && w_done) begin
            if (b_hit || b_got) begin
              bus.bready <= 1'b0;
              resp_rdata <= '0;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              state      <= RESP;
            end else begin
              state <= WR_RESP;
            end
          end
        end
        WR_RESP: if (b_hit) begin
          bus.bready <= 1'b0;
          resp_rdata <= '0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Directed bench for axi_lite_mem_master: loads, stores, misalignment, back-to-back and mid-flight reset.
module tb_axi_lite_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int          vectors = 0;
  int          miscompares = 0;

  axi_lite_mem_master_if #(.ADDR_W(32), .DATA_W(32), .STRB_W(8)) bus ();

  axi_lite_mem_master #(.ADDR_W(32), .DATA_W(32), .STRB_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
  endtask

  task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] mem, input logic [31:0] exp,
                          input logic fast);
    req(1'b0, size, uns, addr, 32'h0);
    tick();
    req_valid = 1'b0;
    chk({tag, ".arvalid"}, bus.arvalid, 1);
    chk({tag, ".araddr"}, bus.araddr, addr & 32'hFFFF_FFFC);
    chk({tag, ".rready"}, bus.rready, 1);
    if (fast) begin
      bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = mem;
      tick();
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
    end else begin
      tick();
      chk({tag, ".arvalid_hold"}, bus.arvalid, 1);
      bus.arready = 1'b1;
      tick();
      bus.arready = 1'b0;
      chk({tag, ".arvalid_drop"}, bus.arvalid, 0);
      tick();
      chk({tag, ".rready_wait"}, bus.rready, 1);
      chk({tag, ".no_early_resp"}, resp_valid, 0);
      bus.rvalid = 1'b1; bus.rdata = mem;
      tick();
      bus.rvalid = 1'b0; bus.rdata = 32'h0;
    end
    chk({tag, ".resp_valid"}, resp_valid, 1);
    chk({tag, ".rdata"}, resp_rdata, exp);
    chk({tag, ".err"}, resp_err, 0);
    chk({tag, ".rready_drop"}, bus.rready, 0);
    tick();
    chk({tag, ".resp_once"}, resp_valid, 0);
    chk({tag, ".req_ready"}, req_ready, 1);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    bus.arready = 1'b0; bus.rdata = 32'h0; bus.rresp = 1'b0; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bresp = 1'b0; bus.bvalid = 1'b0;
    tick();
    tick();
    chk("rst.arvalid", bus.arvalid, 0);
    chk("rst.rready", bus.rready, 0);
    chk("rst.awvalid", bus.awvalid, 0);
    chk("rst.wvalid", bus.wvalid, 0);
    chk("rst.bready", bus.bready, 0);
    chk("rst.resp_valid", resp_valid, 0);
    chk("rst.resp_err", resp_err, 0);
    chk("rst.araddr", bus.araddr, 0);
    chk("rst.awaddr", bus.awaddr, 0);
    chk("rst.wdata", bus.wdata, 0);
    chk("rst.wstrb", bus.wstrb, 0);
    chk("rst.resp_rdata", resp_rdata, 0);
    chk("rst.req_ready", req_ready, 1);
    rst = 1'b1;
    tick();

    // Loads against the word 0x8081_8283
    run_load("ldw",   32'h100, 2'd2, 1'b0, 32'h8081_8283, 32'h8081_8283, 1'b0);
    run_load("ldb_s", 32'h103, 2'd0, 1'b0, 32'h8081_8283, 32'hFFFF_FF80, 1'b1);
    run_load("ldb_u", 32'h103, 2'd0, 1'b1, 32'h8081_8283, 32'h0000_0080, 1'b1);
    run_load("ldh_s", 32'h102, 2'd1, 1'b0, 32'h8081_8283, 32'hFFFF_8081, 1'b1);
    run_load("ldh_u", 32'h100, 2'd1, 1'b1, 32'h8081_8283, 32'h0000_8283, 1'b1);
    run_load("ldb_1", 32'h101, 2'd0, 1'b0, 32'h8081_7F83, 32'h0000_007F, 1'b1);

    // Byte store
    req(1'b1, 2'd0, 1'b0, 32'h201, 32'h0000_00AB);
    tick();
    req_valid = 1'b0;
    chk("stb.awvalid", bus.awvalid, 1);
    chk("stb.wvalid", bus.wvalid, 1);
    chk("stb.awaddr", bus.awaddr, 32'h200);
    chk("stb.wdata", bus.wdata, 32'h0000_AB00);
    chk("stb.wstrb", bus.wstrb, 8'h02);
    chk("stb.bready", bus.bready, 1);
    chk("stb.arvalid", bus.arvalid, 0);
    bus.awready = 1'b1; bus.wready = 1'b1;
    tick();
    bus.awready = 1'b0; bus.wready = 1'b0;
    chk("stb.awvalid_drop", bus.awvalid, 0);
    chk("stb.wvalid_drop", bus.wvalid, 0);
    chk("stb.bready_hold", bus.bready, 1);
    chk("stb.no_early_resp", resp_valid, 0);
    bus.bvalid = 1'b1;
    tick();
    bus.bvalid = 1'b0;
    chk("stb.resp_valid", resp_valid, 1);
    chk("stb.resp_rdata", resp_rdata, 0);
    chk("stb.bready_drop", bus.bready, 0);
    tick();
    chk("stb.resp_once", resp_valid, 0);

    // Misaligned requests: word load at 0x102, half store at 0x203, size 3
    req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("mis_ld.resp_valid", resp_valid, 1);
    chk("mis_ld.err", resp_err, 1);
    chk("mis_ld.arvalid", bus.arvalid, 0);
    chk("mis_ld.rready", bus.rready, 0);
    tick();
    chk("mis_ld.resp_once", resp_valid, 0);
    chk("mis_ld.err_clr", resp_err, 0);
    chk("mis_ld.arvalid2", bus.arvalid, 0);
    req(1'b1, 2'd1, 1'b0, 32'h203, 32'h55);
    tick();
    req_valid = 1'b0;
    chk("mis_st.resp_valid", resp_valid, 1);
    chk("mis_st.err", resp_err, 1);
    chk("mis_st.awvalid", bus.awvalid, 0);
    chk("mis_st.wvalid", bus.wvalid, 0);
    tick();
    chk("mis_st.awvalid2", bus.awvalid, 0);
    chk("mis_st.resp_once", resp_valid, 0);
    req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("sz3.err", resp_err, 1);
    chk("sz3.arvalid", bus.arvalid, 0);
    tick();

    // Back-to-back half stores with req_valid held, split handshakes, bvalid 5 cycles late
    req(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_1234);
    tick();
    chk("b2b.awvalid", bus.awvalid, 1);
    chk("b2b.wvalid", bus.wvalid, 1);
    chk("b2b.wdata", bus.wdata, 32'h1234_0000);
    chk("b2b.wstrb", bus.wstrb, 8'h0C);
    chk("b2b.req_ready", req_ready, 0);
    bus.awready = 1'b1;
    tick();
    bus.awready = 1'b0;
    chk("b2b.aw_only_drop", bus.awvalid, 0);
    chk("b2b.w_hold", bus.wvalid, 1);
    chk("b2b.wdata_hold", bus.wdata, 32'h1234_0000);
    bus.wready = 1'b1;
    tick();
    bus.wready = 1'b0;
    chk("b2b.w_drop", bus.wvalid, 0);
    for (int i = 0; i < 5; i++) begin
      chk("b2b.bready_wait", bus.bready, 1);
      chk("b2b.busy", req_ready, 0);
      chk("b2b.no_resp", resp_valid, 0);
      tick();
    end
    bus.bvalid = 1'b1;
    tick();
    bus.bvalid = 1'b0;
    chk("b2b.resp_valid", resp_valid, 1);
    chk("b2b.req_ready_resp", req_ready, 0);
    chk("b2b.bready_drop", bus.bready, 0);
    tick();
    chk("b2b.idle_ready", req_ready, 1);
    chk("b2b.resp_once", resp_valid, 0);
    chk("b2b.not_yet", bus.awvalid, 0);
    tick();
    req_valid = 1'b0;
    chk("b2b.second_acc", bus.awvalid, 1);
    chk("b2b.second_busy", req_ready, 0);
    // Both handshakes and the write response all land in one cycle
    bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b1;
    tick();
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
    chk("b2b.same_cycle_resp", resp_valid, 1);
    chk("b2b.same_cycle_aw", bus.awvalid, 0);
    chk("b2b.same_cycle_w", bus.wvalid, 0);
    chk("b2b.same_cycle_b", bus.bready, 0);
    tick();
    chk("b2b.second_once", resp_valid, 0);

    // Asynchronous reset while waiting in RD_DATA
    req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    tick();
    req_valid = 1'b0;
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    chk("arst.in_rd_data", bus.rready, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst.rready", bus.rready, 0);
    chk("arst.arvalid", bus.arvalid, 0);
    chk("arst.resp_valid", resp_valid, 0);
    chk("arst.req_ready", req_ready, 1);
    chk("arst.araddr", bus.araddr, 0);
    #2 rst = 1'b1;
    bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF;
    tick();
    bus.rvalid = 1'b0; bus.rdata = 32'h0;
    chk("arst.abandoned", resp_valid, 0);
    chk("arst.idle", req_ready, 1);
    run_load("post_rst", 32'h100, 2'd2, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
